// File: rtl/coverage_readout_if.sv
// coverage_readout_if: coverage RAM read port plus packed-word output stream
//   mem_rd/mem_addr/mem_rdata : 1-bit coverage RAM, combinational read
//   out_data/out_valid/out_ready/out_last : valid/ready word stream
//   master = readout engine side, slave = RAM + consumer side
interface coverage_readout_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 8
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rdata;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    modport master (
        output mem_rd, mem_addr, out_data, out_valid, out_last,
        input  mem_rdata, out_ready
    );
    modport slave (
        input  mem_rd, mem_addr, out_data, out_valid, out_last,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/coverage_readout.sv
// coverage_readout: walks the 1-bit coverage RAM and streams it out as LSB-first packed words
//   clk, rst    : clock, asynchronous active-high reset
//   start       : 1-cycle pulse, accepted only in IDLE
//   num_points  : point count N sampled with start, clamped to 2**ADDR_W
//   busy        : pass in progress
//   hit_count   : number of covered points seen in the current/last pass
//   done        : 1-cycle pulse at end of pass
//   bus         : RAM read port and output word stream (master side)
module coverage_readout #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W:0]     num_points,
    output logic                busy,
    output logic [ADDR_W:0]     hit_count,
    output logic                done,
    coverage_readout_if.master  bus
);
    localparam int BI_W = $clog2(WORD_W);
    localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};
    typedef enum logic [1:0] {IDLE, READ, EMIT, FIN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] last_addr;
    logic [BI_W-1:0]   bit_idx;
    logic [WORD_W-1:0] shift;
    logic [WORD_W-1:0] shift_nxt;
    logic [ADDR_W:0]   n_clamp;
    logic [ADDR_W:0]   n_m1;
    logic              pass_end;
    logic              word_end;
    always_comb begin
        n_clamp   = num_points > N_MAX ? N_MAX : num_points;
        n_m1      = n_clamp - (ADDR_W+1)'(1);
        shift_nxt = shift | (WORD_W'(bus.mem_rdata) << bit_idx);
        pass_end  = bus.mem_addr == last_addr;
        word_end  = bit_idx == BI_W'(WORD_W-1) || pass_end;
    end
    // mem_addr only advances when another read follows, so it keeps the last
    // address read while a word waits in EMIT and after the pass ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            hit_count     <= '0;
            last_addr     <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    hit_count <= '0;
                    bit_idx   <= '0;
                    shift     <= '0;
                    if (n_clamp != '0) begin
                        state        <= READ;
                        last_addr    <= n_m1[ADDR_W-1:0];
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= '0;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                READ: begin
                    shift     <= shift_nxt;
                    hit_count <= hit_count + (ADDR_W+1)'(bus.mem_rdata);
                    bit_idx   <= bit_idx + BI_W'(1);
                    if (word_end) begin
                        state         <= EMIT;
                        bus.mem_rd    <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= shift_nxt;
                        bus.out_last  <= pass_end;
                    end else begin
                        bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                    end
                end
                EMIT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    if (bus.out_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state        <= READ;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                        bit_idx      <= '0;
                        shift        <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
    // One word in flight: the RAM is never read while a word is offered.
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid |-> !bus.mem_rd);
    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data) && $stable(bus.mem_addr));
endmodule

// File: tb/tb_coverage_readout.sv
// tb_coverage_readout: directed self-checking bench for coverage_readout
module tb_coverage_readout;
    localparam int ADDR_W = 12;
    localparam int WORD_W = 8;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_points = '0;
    logic              busy;
    logic [ADDR_W:0]   hit_count;
    logic              done;
    logic              ram [1<<ADDR_W];
    logic [WORD_W-1:0] q_data [$];
    logic              q_last [$];
    int                n_done;
    int                n_cmp = 0;
    int                n_bad = 0;
    int                pop;
    coverage_readout_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();
    coverage_readout #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_points(num_points),
        .busy(busy), .hit_count(hit_count), .done(done), .bus(bus)
    );
    assign bus.mem_rdata = ram[bus.mem_addr];
    always #5 clk = ~clk;

    task automatic load_bits(input int base, input logic [7:0] v);
        for (int i = 0; i < 8; i++) ram[base+i] = v[i];
    endtask

    // Start a pass with out_ready=1 and collect every accepted word until done.
    task automatic run_pass(input logic [ADDR_W:0] n, input int budget, input int restart_at);
        q_data.delete();
        q_last.delete();
        n_done = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        num_points = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < budget; c++) begin
            start = (c == restart_at);
            if (c == restart_at) num_points = 13'd5;
            if (bus.out_valid && bus.out_ready) begin
                q_data.push_back(bus.out_data);
                q_last.push_back(bus.out_last);
            end
            if (done) begin
                n_done++;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (bus.mem_rd !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rd got %b want 0", bus.mem_rd); end
        n_cmp++; if (bus.mem_addr !== 12'd0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
        n_cmp++; if (hit_count !== 13'd0) begin n_bad++; $display("FAIL reset_hit_count got %0d want 0", hit_count); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_single_word;
        load_bits(0, 8'hA5);
        bus.out_ready = 1'b1;
        @(negedge clk);
        num_points = 13'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL a5_busy_c1 got %b want 1", busy); end
        n_cmp++; if (bus.mem_rd !== 1'b1) begin n_bad++; $display("FAIL a5_mem_rd_c1 got %b want 1", bus.mem_rd); end
        n_cmp++; if (bus.mem_addr !== 12'd0) begin n_bad++; $display("FAIL a5_addr_c1 got %0d want 0", bus.mem_addr); end
        repeat (7) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL a5_valid_c8 got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.mem_addr !== 12'd7) begin n_bad++; $display("FAIL a5_addr_c8 got %0d want 7", bus.mem_addr); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL a5_valid_c9 got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'hA5) begin n_bad++; $display("FAIL a5_data got %h want a5", bus.out_data); end
        n_cmp++; if (bus.out_last !== 1'b1) begin n_bad++; $display("FAIL a5_last got %b want 1", bus.out_last); end
        n_cmp++; if (bus.mem_rd !== 1'b0) begin n_bad++; $display("FAIL a5_mem_rd_c9 got %b want 0", bus.mem_rd); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL a5_done_c10 got %b want 1", done); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL a5_valid_c10 got %b want 0", bus.out_valid); end
        n_cmp++; if (hit_count !== 13'd4) begin n_bad++; $display("FAIL a5_hits got %0d want 4", hit_count); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL a5_done_c11 got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy_c11 got %b want 0", busy); end
        n_cmp++; if (bus.mem_addr !== 12'd7) begin n_bad++; $display("FAIL a5_addr_hold got %0d want 7", bus.mem_addr); end
    endtask

    task automatic test_partial_word;
        for (int i = 0; i < 16; i++) ram[i] = 1'b1;
        run_pass(13'd11, 100, 0);
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL part_done got %0d want 1", n_done); end
        n_cmp++; if (q_data.size() !== 2) begin n_bad++; $display("FAIL part_words got %0d want 2", q_data.size()); end
        if (q_data.size() == 2) begin
            n_cmp++; if (q_data[0] !== 8'hFF) begin n_bad++; $display("FAIL part_w0 got %h want ff", q_data[0]); end
            n_cmp++; if (q_last[0] !== 1'b0) begin n_bad++; $display("FAIL part_last0 got %b want 0", q_last[0]); end
            n_cmp++; if (q_data[1] !== 8'h07) begin n_bad++; $display("FAIL part_w1 got %h want 07", q_data[1]); end
            n_cmp++; if (q_last[1] !== 1'b1) begin n_bad++; $display("FAIL part_last1 got %b want 1", q_last[1]); end
        end
        n_cmp++; if (hit_count !== 13'd11) begin n_bad++; $display("FAIL part_hits got %0d want 11", hit_count); end
    endtask

    task automatic test_stall;
        load_bits(0, 8'h3C);
        load_bits(8, 8'hC3);
        bus.out_ready = 1'b0;
        @(negedge clk);
        num_points = 13'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !bus.out_valid; c++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", k, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 8'h3C) begin n_bad++; $display("FAIL stall_data[%0d] got %h want 3c", k, bus.out_data); end
            n_cmp++; if (bus.mem_rd !== 1'b0) begin n_bad++; $display("FAIL stall_mem_rd[%0d] got %b want 0", k, bus.mem_rd); end
            n_cmp++; if (bus.mem_addr !== 12'd7) begin n_bad++; $display("FAIL stall_addr[%0d] got %0d want 7", k, bus.mem_addr); end
            if (k < 4) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_post_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.mem_rd !== 1'b1) begin n_bad++; $display("FAIL stall_post_rd got %b want 1", bus.mem_rd); end
        n_cmp++; if (bus.mem_addr !== 12'd8) begin n_bad++; $display("FAIL stall_post_addr got %0d want 8", bus.mem_addr); end
        for (int c = 0; c < 20 && !bus.out_valid; c++) @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'hC3) begin n_bad++; $display("FAIL stall_w1 got %h want c3", bus.out_data); end
        n_cmp++; if (bus.out_last !== 1'b1) begin n_bad++; $display("FAIL stall_last1 got %b want 1", bus.out_last); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done got %b want 1", done); end
        n_cmp++; if (hit_count !== 13'd8) begin n_bad++; $display("FAIL stall_hits got %0d want 8", hit_count); end
    endtask

    task automatic test_zero_points;
        logic saw_valid;
        saw_valid = 1'b0;
        @(negedge clk);
        num_points = 13'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_valid |= bus.out_valid;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done got %b want 1", done); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy got %b want 1", busy); end
        n_cmp++; if (hit_count !== 13'd0) begin n_bad++; $display("FAIL zero_hits got %0d want 0", hit_count); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            saw_valid |= bus.out_valid;
        end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_after got %b want 0", done); end
        n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid got %b want 0", saw_valid); end
    endtask

    task automatic test_reset_mid_pass;
        logic saw_evt;
        saw_evt = 1'b0;
        load_bits(0, 8'hA5);
        bus.out_ready = 1'b1;
        @(negedge clk);
        num_points = 13'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.mem_addr !== 12'd3) begin n_bad++; $display("FAIL rmid_addr got %0d want 3", bus.mem_addr); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (bus.mem_rd !== 1'b0) begin n_bad++; $display("FAIL rmid_mem_rd got %b want 0", bus.mem_rd); end
        n_cmp++; if (bus.mem_addr !== 12'd0) begin n_bad++; $display("FAIL rmid_mem_addr got %0d want 0", bus.mem_addr); end
        n_cmp++; if (hit_count !== 13'd0) begin n_bad++; $display("FAIL rmid_hits got %0d want 0", hit_count); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            saw_evt |= done | bus.out_valid;
        end
        n_cmp++; if (saw_evt !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done got %b want 0", saw_evt); end
        run_pass(13'd8, 50, 0);
        n_cmp++; if (q_data.size() !== 1) begin n_bad++; $display("FAIL rmid_words got %0d want 1", q_data.size()); end
        if (q_data.size() == 1) begin
            n_cmp++; if (q_data[0] !== 8'hA5) begin n_bad++; $display("FAIL rmid_word got %h want a5", q_data[0]); end
            n_cmp++; if (q_last[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_last got %b want 1", q_last[0]); end
        end
        n_cmp++; if (hit_count !== 13'd4) begin n_bad++; $display("FAIL rmid_hits2 got %0d want 4", hit_count); end
    endtask

    task automatic test_full_ram(input logic [ADDR_W:0] n, input int restart_at);
        logic [WORD_W-1:0] exp_w;
        run_pass(n, 6000, restart_at);
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL full%0d_done got %0d want 1", n, n_done); end
        n_cmp++; if (q_data.size() !== 512) begin n_bad++; $display("FAIL full%0d_words got %0d want 512", n, q_data.size()); end
        for (int w = 0; w < q_data.size(); w++) begin
            for (int i = 0; i < WORD_W; i++) exp_w[i] = ram[w*WORD_W+i];
            n_cmp++; if (q_data[w] !== exp_w) begin n_bad++; $display("FAIL full%0d_w[%0d] got %h want %h", n, w, q_data[w], exp_w); end
            n_cmp++; if (q_last[w] !== (w == 511)) begin n_bad++; $display("FAIL full%0d_last[%0d] got %b want %b", n, w, q_last[w], w == 511); end
        end
        n_cmp++; if (hit_count !== (ADDR_W+1)'(pop)) begin n_bad++; $display("FAIL full%0d_hits got %0d want %0d", n, hit_count, pop); end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_word();
        test_partial_word();
        test_stall();
        test_zero_points();
        test_reset_mid_pass();
        pop = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i] = 1'($urandom_range(0, 1));
            pop += int'(ram[i]);
        end
        test_full_ram(13'd4096, 3);
        test_full_ram(13'd8191, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
